mult_div_sequencer: RTL and testbench

//   Multi-cycle iterative multiply/divide responder for the execute stage.

---
 rtl/mult_div_sequencer_if.sv | 32 +++
 rtl/mult_div_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_sequencer_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The flush wire exists only when MDU_FLUSH_EN is defined.
interface mult_div_sequencer_if #(parameter int DATA_WIDTH = 32);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] operandA;
    logic [DATA_WIDTH-1:0] operandB;
`ifdef MDU_FLUSH_EN
    logic                  flush;
`endif
    logic                  busy;
    logic                  done;
    logic                  divByZero;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
`ifdef MDU_FLUSH_EN
        output flush,
`endif
        output start, op, operandA, operandB,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
`ifdef MDU_FLUSH_EN
        input  flush,
`endif
        input  start, op, operandA, operandB,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit: IDLE -> PREP -> RUN -> FIX, one bit per clock.
// Optional cancel input is compiled in with the MDU_FLUSH_EN macro.
module mult_div_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_div_sequencer_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [CW-1:0] ITER    = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        return ~v + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v, input logic is_signed);
        if (is_signed && v[W-1]) begin
            return neg_w(v);
        end else begin
            return v;
        end
    endfunction

    logic [1:0]     r_state;
    logic [1:0]     r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [W-1:0]   r_mcand;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_neg_lo;
    logic           r_neg_hi;
    logic           r_busy;
    logic           r_done;
    logic           r_dbz;
    logic [W-1:0]   r_hi;
    logic [W-1:0]   r_lo;

    logic           w_flush;
    logic           w_signed;
    logic           w_sign_a;
    logic           w_sign_b;
    logic [W:0]     w_mul_sum;
    logic [W:0]     w_div_shift;
    logic [W:0]     w_div_trial;
    logic           w_div_ok;
    logic [2*W-1:0] w_step;
    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic           w_dbz;
    logic [W-1:0]   w_hi;
    logic [W-1:0]   w_lo;

`ifdef MDU_FLUSH_EN
    assign w_flush = bus.flush & r_busy;
`else
    assign w_flush = 1'b0;
`endif

    // op[0] set means the unsigned variant
    assign w_signed = ~r_op[0];
    assign w_sign_a = w_signed & r_a[W-1];
    assign w_sign_b = w_signed & r_b[W-1];

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_mcand : {W{1'b0}})};
        w_div_shift = r_acc[2*W-1:W-1];
        w_div_trial = w_div_shift - {1'b0, r_mcand};
        w_div_ok    = ~w_div_trial[W];
        if (r_op[1]) begin
            w_step = {(w_div_ok ? w_div_trial[W-1:0] : w_div_shift[W-1:0]), r_acc[W-2:0], w_div_ok};
        end else begin
            w_step = {w_mul_sum, r_acc[W-1:1]};
        end
    end

    // Sign correction and special-case selection of the final HI/LO
    always_comb begin
        w_prod = r_neg_lo ? neg_2w(r_acc) : r_acc;
        w_quo  = r_neg_lo ? neg_w(r_acc[W-1:0]) : r_acc[W-1:0];
        w_rem  = r_neg_hi ? neg_w(r_acc[2*W-1:W]) : r_acc[2*W-1:W];
        w_dbz  = r_op[1] & (r_b == {W{1'b0}});
        if (w_dbz) begin
            w_hi = r_a;
            w_lo = {W{1'b1}};
        end else if (r_op[1]) begin
            w_hi = w_rem;
            w_lo = w_quo;
        end else begin
            w_hi = w_prod[2*W-1:W];
            w_lo = w_prod[W-1:0];
        end
    end

    // Sequencer state and handshake flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (w_flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_PREP;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_PREP: begin
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        if (r_cnt == CNT_ONE) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_dbz   <= w_dbz;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Operand capture, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= 2'b00;
            r_a      <= {W{1'b0}};
            r_b      <= {W{1'b0}};
            r_mcand  <= {W{1'b0}};
            r_acc    <= {(2*W){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_hi     <= {W{1'b0}};
            r_lo     <= {W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op <= bus.op;
                        r_a  <= bus.operandA;
                        r_b  <= bus.operandB;
                    end
                end
                S_PREP: begin
                    r_neg_lo <= w_sign_a ^ w_sign_b;
                    r_neg_hi <= w_sign_a;
                    r_cnt    <= ITER;
                    // Divide: accumulator low half holds the dividend, r_mcand the divisor
                    if (r_op[1]) begin
                        r_acc   <= {{W{1'b0}}, abs_w(r_a, w_signed)};
                        r_mcand <= abs_w(r_b, w_signed);
                    end else begin
                        r_acc   <= {{W{1'b0}}, abs_w(r_b, w_signed)};
                        r_mcand <= abs_w(r_a, w_signed);
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - CNT_ONE;
                end
                S_FIX: begin
                    if (!w_flush) begin
                        r_hi <= w_hi;
                        r_lo <= w_lo;
                    end
                end
                default: begin
                    r_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.divByZero = r_dbz;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed + randomized bench for mult_div_sequencer, checked against an arithmetic reference.
module tb_mult_div_sequencer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mult_div_sequencer_if #(.DATA_WIDTH(W)) bus ();
    mult_div_sequencer #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        int          sa, sb, q, r;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        dbz = 1'b0;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                {hi, lo} = p;
            end
            2'b01: begin
                pu = {32'd0, a} * {32'd0, b};
                {hi, lo} = pu;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = 32'd0; lo = 32'h8000_0000;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    hi = r; lo = q;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
                end else begin
                    hi = a % b; lo = a / b;
                end
            end
        endcase
    endfunction

    // Launch one op, wait (bounded) for done, check latency, result, pulse width and hold.
    task automatic run_exp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input logic edbz);
        int          n;
        logic        held;
        logic [31:0] ph, pl;
        ph = bus.hi;
        pl = bus.lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operandA = a; bus.operandB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.operandA = $urandom; bus.operandB = $urandom;
        check({tag, ".busy_on"}, bus.busy, 1'b1);
        n = 0;
        held = 1'b1;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!bus.done && (bus.hi !== ph || bus.lo !== pl)) held = 1'b0;
        end
        check({tag, ".latency"}, n, 34);
        check({tag, ".hold_during"}, held, 1'b1);
        check({tag, ".hi"}, bus.hi, eh);
        check({tag, ".lo"}, bus.lo, el);
        check({tag, ".dbz"}, bus.divByZero, edbz);
        check({tag, ".busy_off"}, bus.busy, 1'b0);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, bus.done, 1'b0);
        check({tag, ".dbz_pulse"}, bus.divByZero, 1'b0);
        check({tag, ".hi_hold"}, bus.hi, eh);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edbz;
        model(op, a, b, eh, el, edbz);
        run_exp(tag, op, a, b, eh, el, edbz);
    endtask

    initial begin
        int          n;
        logic        seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          sel;

        bus.start = 1'b0; bus.op = 2'b00; bus.operandA = 32'd0; bus.operandB = 32'd0;
`ifdef MDU_FLUSH_EN
        bus.flush = 1'b0;
`endif
        reset = 1'b1;
        #12;
        check("reset.busy", bus.busy, 1'b0);
        check("reset.done", bus.done, 1'b0);
        check("reset.dbz", bus.divByZero, 1'b0);
        check("reset.hi", bus.hi, 32'd0);
        check("reset.lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_exp("mult_7x6", 2'b00, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
        run_exp("mult_neg1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_exp("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
        run_exp("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_exp("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_exp("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_exp("divu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        run_exp("div_by0", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1);

        // start while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.operandA = 32'd9; bus.operandB = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 10) begin
                bus.start = 1'b1; bus.op = 2'b00; bus.operandA = 32'd100; bus.operandB = 32'd7;
                @(posedge clk); #1;
                n++;
                bus.start = 1'b0;
            end
        end
        check("ignore.latency", n, 34);
        check("ignore.lo", bus.lo, 32'd3);
        check("ignore.hi", bus.hi, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ignore.no_relaunch", bus.busy, 1'b0);

        run_exp("divu_17_5", 2'b11, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0);

        // asynchronous reset in the middle of an op
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operandA = 32'd123; bus.operandB = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset.busy", bus.busy, 1'b0);
        check("midreset.hi", bus.hi, 32'd0);
        check("midreset.lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        check("midreset.no_done", seen, 1'b0);
        check("midreset.idle", bus.busy, 1'b0);

`ifdef MDU_FLUSH_EN
        run_exp("flush_pre_5x5", 2'b00, 32'd5, 32'd5, 32'd0, 32'd25, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.operandA = 32'd3; bus.operandB = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush.busy", bus.busy, 1'b0);
        check("flush.done", bus.done, 1'b0);
        check("flush.lo_kept", bus.lo, 32'd25);
        run_exp("flush_post_4x4", 2'b00, 32'd4, 32'd4, 32'd0, 32'd16, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'($urandom_range(1, 15));
            if (sel == 2) ra = 32'h8000_0000;
            if (sel == 3) ra = 32'($urandom_range(0, 255));
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
